fetch_queue: RTL and testbench

- Dual-issue instruction buffer between the fetch stage and the decode stage.
- Captures up to two fetched instructions per cycle (slot 0 at pcf, slot 1 at pcf+4) into a circular FIFO.
- Presents the two oldest entries to decode and retires up to two per cycle.
- Decouples decode stalls from fetch: stallf is back-pressure to the PC register; flush (mispredict/clrbp) discards all buffered instructions.

---
 rtl/fetch_queue_if.sv | 34 +++
 rtl/fetch_queue.sv | 118 +++++++++++
 tb/tb_fetch_queue.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for the dual-issue instruction buffer.
// The master side is the pipeline (fetch drives pushes, decode drives stalld);
// the slave side is the queue itself.
interface fetch_queue_if #(
  parameter int WIDTH = 32
);
  // Fetch side
  logic             flush;
  logic             validf;
  logic             validf2;
  logic [WIDTH-1:0] instrf;
  logic [WIDTH-1:0] instrf2;
  logic [WIDTH-1:0] pcf;
  logic             stallf;

  // Decode side
  logic             stalld;
  logic [WIDTH-1:0] instrd;
  logic [WIDTH-1:0] instrd2;
  logic [WIDTH-1:0] pcd;
  logic [WIDTH-1:0] pcd2;
  logic             validd;
  logic             validd2;

  modport master (
    output flush, validf, validf2, instrf, instrf2, pcf, stalld,
    input  stallf, instrd, instrd2, pcd, pcd2, validd, validd2
  );

  modport slave (
    input  flush, validf, validf2, instrf, instrf2, pcf, stalld,
    output stallf, instrd, instrd2, pcd, pcd2, validd, validd2
  );
endinterface

// File: rtl/fetch_queue.sv
// Dual-issue instruction buffer between fetch and decode.
// Accepts up to two instructions per cycle (slot 1 at pcf+4) into a circular
// FIFO and presents the two oldest entries to decode, retiring up to two per
// cycle. stallf back-pressures the PC register when fewer than two slots are
// free; flush (redirect) empties the queue without touching storage.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  fetch_queue_if.slave fq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          full2;
  logic          push_ok;
  logic          push_two;
  logic [1:0]    pushn;
  logic [1:0]    popn;
  logic [AW-1:0] wr_ptr1;
  logic [AW-1:0] rd_ptr1;
  logic [CW-1:0] count_next;
  logic [AW-1:0] rd_ptr_next;
  logic [AW-1:0] wr_ptr_next;
  logic          occ1;
  logic          occ2;

  // Fewer than two free slots: a 2-wide push might not fit, so hold fetch.
  // Derived only from registered count, so it carries no input-to-output path.
  assign full2   = count > CW'(DEPTH - 2);
  assign occ1    = count != '0;
  assign occ2    = count > CW'(1);

  // Pointer+1 wraps naturally because the pointers are exactly clog2(DEPTH) wide.
  assign wr_ptr1 = wr_ptr + AW'(1);
  assign rd_ptr1 = rd_ptr + AW'(1);

  // Push/pop sizing and next-state bookkeeping for pointers and occupancy.
  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    push_ok     = 1'b0;
    push_two    = 1'b0;
    pushn       = 2'd0;
    popn        = 2'd0;
    count_next  = count;
    rd_ptr_next = rd_ptr;
    wr_ptr_next = wr_ptr;

    // A request while stalled is dropped; fetch replays it from the held PC.
    if (fq.validf && !full2) begin
      push_ok  = 1'b1;
      push_two = fq.validf2;
      pushn    = fq.validf2 ? 2'd2 : 2'd1;
    end

    // Pops see only pre-edge occupancy, never this cycle's push.
    if (!fq.stalld) begin
      popn = {1'b0, occ1} + {1'b0, occ2};
    end

    count_next  = count + CW'(pushn) - CW'(popn);
    wr_ptr_next = wr_ptr + AW'(pushn);
    rd_ptr_next = rd_ptr + AW'(popn);
  end

  // Queue bookkeeping; reset and flush both empty the queue and override traffic.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset || fq.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_next;
      wr_ptr <= wr_ptr_next;
      count  <= count_next;
    end
  end

  // Entry storage; slot 0 at the tail, slot 1 right behind it (wrapping).
  // NOTE: storage is cleared on reset only so decode outputs are deterministic
  // from the first cycle; flush leaves stale contents in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok && !fq.flush) begin
      mem[wr_ptr] <= '{pc: fq.pcf, instr: fq.instrf};
      if (push_two) begin
        mem[wr_ptr1] <= '{pc: fq.pcf + WIDTH'(4), instr: fq.instrf2};
      end
    end
  end

  // Decode view: unconditional reads of the two oldest entries, no bypass.
  assign fq.instrd  = mem[rd_ptr].instr;
  assign fq.pcd     = mem[rd_ptr].pc;
  assign fq.instrd2 = mem[rd_ptr1].instr;
  assign fq.pcd2    = mem[rd_ptr1].pc;
  assign fq.validd  = occ1;
  assign fq.validd2 = occ2;
  assign fq.stallf  = full2;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a scoreboard queue receives accepted
// instructions when fetch drives them and is compared against the decode
// outputs every cycle; entries are retired when decode pops.
module tb_fetch_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  typedef struct {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } ent_t;

  logic clk;
  logic reset;

  fetch_queue_if #(.WIDTH(WIDTH)) fq ();

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec;
  int   n_err;
  ent_t sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, compare the settled
  // decode view against the scoreboard, update the scoreboard as the queue
  // should on the coming rising edge, then advance to the next falling edge.
  task automatic step(input logic vf, input logic vf2, input logic [WIDTH-1:0] pc,
                      input logic [WIDTH-1:0] i0, input logic [WIDTH-1:0] i1,
                      input logic sd, input logic fl, input logic rs);
    int   npop;
    logic accept;
    fq.validf  = vf;
    fq.validf2 = vf2;
    fq.pcf     = pc;
    fq.instrf  = i0;
    fq.instrf2 = i1;
    fq.stalld  = sd;
    fq.flush   = fl;
    reset      = rs;
    #1;
    check("validd", fq.validd, sb.size() >= 1);
    check("validd2", fq.validd2, sb.size() >= 2);
    check("stallf", fq.stallf, sb.size() > DEPTH - 2);
    check("count", dut.count, sb.size());
    check("count_le_depth", dut.count <= DEPTH, 1'b1);
    if (sb.size() >= 1) begin
      check("pcd", fq.pcd, sb[0].pc);
      check("instrd", fq.instrd, sb[0].instr);
    end
    if (sb.size() >= 2) begin
      check("pcd2", fq.pcd2, sb[1].pc);
      check("instrd2", fq.instrd2, sb[1].instr);
    end
    accept = vf && !(sb.size() > DEPTH - 2);
    if (rs || fl) begin
      sb.delete();
    end else begin
      npop = sd ? 0 : (sb.size() >= 2 ? 2 : sb.size());
      repeat (npop) void'(sb.pop_front());
      if (accept) begin
        sb.push_back('{pc, i0});
        if (vf2) sb.push_back('{pc + 32'd4, i1});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic sd);
    step(1'b0, 1'b0, '0, '0, '0, sd, 1'b0, 1'b0);
  endtask

  task automatic push2(input logic [WIDTH-1:0] pc, input logic sd);
    step(1'b1, 1'b1, pc, pc ^ 32'hA5A5_0000, pc ^ 32'h5A5A_0000, sd, 1'b0, 1'b0);
  endtask

  task automatic push1(input logic [WIDTH-1:0] pc, input logic sd);
    step(1'b1, 1'b0, pc, pc ^ 32'hC3C3_0000, 32'hFFFF_FFFF, sd, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    fq.validf  = 1'b0;
    fq.validf2 = 1'b0;
    fq.pcf     = '0;
    fq.instrf  = '0;
    fq.instrf2 = '0;
    fq.stalld  = 1'b0;
    fq.flush   = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state and idle
    check("rst_stallf", fq.stallf, 1'b0);
    check("rst_validd", fq.validd, 1'b0);
    check("rst_validd2", fq.validd2, 1'b0);
    check("rst_pcd", fq.pcd, 32'h0);
    check("rst_instrd2", fq.instrd2, 32'h0);
    repeat (3) idle(1'b0);

    // Dual push under decode stall, then one release cycle empties it
    step(1'b1, 1'b1, 32'h100, 32'hAAAA_0001, 32'hAAAA_0002, 1'b1, 1'b0, 1'b0);
    check("dual_pcd", fq.pcd, 32'h100);
    check("dual_pcd2", fq.pcd2, 32'h104);
    check("dual_instrd", fq.instrd, 32'hAAAA_0001);
    check("dual_instrd2", fq.instrd2, 32'hAAAA_0002);
    idle(1'b0);
    check("dual_empty", fq.validd, 1'b0);

    // Fill to back-pressure; stallf rises once fewer than two slots are free
    for (int k = 0; k < 4; k++) push2(32'h1000 + 32'(k * 8), 1'b1);
    check("bp_stallf", fq.stallf, 1'b1);
    step(1'b1, 1'b1, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 1'b1, 1'b0, 1'b0);
    check("bp_count_held", dut.count, 4'd8);
    idle(1'b0);
    check("bp_count_after_pop", dut.count, 4'd6);
    check("bp_stallf_low", fq.stallf, 1'b0);
    repeat (3) idle(1'b0);

    // Wrap-around: walk both pointers to DEPTH-1, then straddle 7/0
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      push2(32'h180 + 32'(k * 8), 1'b1);
      idle(1'b0);
    end
    push1(32'h1F0, 1'b1);
    idle(1'b0);
    check("wrap_rd_ptr", dut.rd_ptr, 3'd7);
    check("wrap_wr_ptr", dut.wr_ptr, 3'd7);
    push2(32'h200, 1'b1);
    check("wrap_pcd", fq.pcd, 32'h200);
    check("wrap_pcd2", fq.pcd2, 32'h204);
    idle(1'b0);
    check("wrap_empty", fq.validd, 1'b0);
    check("wrap_rd_ptr_rolled", dut.rd_ptr, 3'd1);

    // Flush beats a simultaneous push and pop
    push2(32'h240, 1'b1);
    push2(32'h248, 1'b1);
    push1(32'h250, 1'b1);
    check("flush_count_pre", dut.count, 4'd5);
    step(1'b1, 1'b1, 32'h260, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, 1'b0);
    check("flush_count", dut.count, 4'd0);
    check("flush_validd", fq.validd, 1'b0);
    check("flush_stallf", fq.stallf, 1'b0);
    push2(32'h300, 1'b1);
    check("flush_next_pcd", fq.pcd, 32'h300);
    idle(1'b0);

    // Odd occupancy: single push, then pop while a 2-wide push lands
    push1(32'h40, 1'b0);
    check("odd_validd", fq.validd, 1'b1);
    check("odd_validd2", fq.validd2, 1'b0);
    check("odd_pcd", fq.pcd, 32'h40);
    push2(32'h48, 1'b0);
    check("odd_pcd_next", fq.pcd, 32'h48);
    check("odd_pcd2_next", fq.pcd2, 32'h4C);
    check("odd_count", dut.count, 4'd2);

    // Reset mid-operation with a push active
    push1(32'h500, 1'b1);
    step(1'b1, 1'b1, 32'h600, 32'h6666_0000, 32'h6666_0004, 1'b0, 1'b0, 1'b1);
    check("mid_rst_validd", fq.validd, 1'b0);
    check("mid_rst_count", dut.count, 4'd0);
    check("mid_rst_pcd", fq.pcd, 32'h0);
    check("mid_rst_instrd", fq.instrd, 32'h0);
    check("mid_rst_pcd2", fq.pcd2, 32'h0);
    check("mid_rst_instrd2", fq.instrd2, 32'h0);

    // Random traffic against the scoreboard
    for (int k = 0; k < 400; k++) begin
      logic [WIDTH-1:0] pc;
      pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, pc,
           $urandom, $urandom, $urandom_range(0, 2) == 0,
           $urandom_range(0, 40) == 0, 1'b0);
    end
    repeat (DEPTH) idle(1'b0);
    check("final_empty", fq.validd, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
